// File: rtl/csr_pkg.sv
// Shared CSR definitions: operation codes, CSR addresses, trap cause codes
// and the bit positions of the implemented status/enable fields.
package csr_pkg;

  localparam int DW    = 32;
  localparam int ADDRW = 12;

  // Operation code produced by the CSR decoder.
  typedef enum logic [2:0] {
    CSR_RW    = 3'b000,
    CSR_RS    = 3'b001,
    CSR_RC    = 3'b010,
    CSR_RWI   = 3'b011,
    CSR_RSI   = 3'b100,
    CSR_RCI   = 3'b101,
    CSR_ILL_6 = 3'b110,
    CSR_ILL_7 = 3'b111
  } csr_op_t;

  localparam logic [ADDRW-1:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [ADDRW-1:0] ADDR_MIE      = 12'h304;
  localparam logic [ADDRW-1:0] ADDR_MTVEC    = 12'h305;
  localparam logic [ADDRW-1:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [ADDRW-1:0] ADDR_MEPC     = 12'h341;
  localparam logic [ADDRW-1:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [ADDRW-1:0] ADDR_MIP      = 12'h344;
  localparam logic [ADDRW-1:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [ADDRW-1:0] ADDR_MCYCLEH  = 12'hB80;

  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTIE_BIT = 7;
  localparam int MEIE_BIT = 11;

  // Only MTIE and MEIE exist in mie.
  localparam logic [DW-1:0] MIE_MASK = 32'h0000_0880;

endpackage

// File: rtl/csr_regfile_if.sv
// CSR access port between the decoder (master) and the register file (slave).
interface csr_regfile_if;
  import csr_pkg::*;

  logic             csr_en_i;
  csr_op_t          csr_op_i;
  logic [ADDRW-1:0] csr_addr_i;
  logic [DW-1:0]    rs1_data_i;
  logic [4:0]       zimm_i;
  logic [DW-1:0]    csr_rdata_o;
  logic             illegal_o;

  modport master (
    output csr_en_i, csr_op_i, csr_addr_i, rs1_data_i, zimm_i,
    input  csr_rdata_o, illegal_o
  );

  modport slave (
    input  csr_en_i, csr_op_i, csr_addr_i, rs1_data_i, zimm_i,
    output csr_rdata_o, illegal_o
  );

endinterface

// File: rtl/csr_wdata.sv
// Operand select and read-modify-write merge for one CSR access.
module csr_wdata
  import csr_pkg::*;
(
  input  csr_op_t       op,
  input  logic [DW-1:0] rs1_data,
  input  logic [4:0]    zimm,
  input  logic [DW-1:0] old,
  output logic [DW-1:0] wdata,
  output logic          src_zero
);

  logic [DW-1:0] src;

  // Pick the source operand, then merge it with the old value.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    src   = rs1_data;
    wdata = old;
    if (op inside {CSR_RWI, CSR_RSI, CSR_RCI}) src = {{(DW-5){1'b0}}, zimm};
    case (op)
      CSR_RW, CSR_RWI: wdata = src;
      CSR_RS, CSR_RSI: wdata = old | src;
      CSR_RC, CSR_RCI: wdata = old & ~src;
      default:         wdata = old;
    endcase
    src_zero = (src == '0);
  end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file with timer/external interrupt entry,
// mret handling and a 64-bit cycle counter.
module csr_regfile
  import csr_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  csr_regfile_if.slave  bus,
  input  logic [DW-1:0] pc_i,
  input  logic          instr_valid_i,
  input  logic          mret_i,
  input  logic          timer_irq_i,
  input  logic          ext_irq_i,
  output logic          redirect_o,
  output logic [DW-1:0] redirect_pc_o
);

  logic          mstatus_mie, mstatus_mpie;
  logic [DW-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0]   mcycle_q;

  logic [DW-1:0] mstatus_val, mip_val, pend, old_val, wdata, vec_base;
  logic          addr_ok, op_ok, illegal, src_zero, set_clear;
  logic          irq, take_mret, csr_we;
  logic [3:0]    cause;

  // Assemble the architecturally visible mstatus and the live mip.
  always_comb begin
    mstatus_val           = '0;
    mstatus_val[MIE_BIT]  = mstatus_mie;
    mstatus_val[MPIE_BIT] = mstatus_mpie;
    mip_val               = '0;
    mip_val[MTIE_BIT]     = timer_irq_i;
    mip_val[MEIE_BIT]     = ext_irq_i;
  end

  // Address decode and old-value read mux.
  always_comb begin
    old_val = '0;
    addr_ok = 1'b1;
    case (bus.csr_addr_i)
      ADDR_MSTATUS:  old_val = mstatus_val;
      ADDR_MIE:      old_val = mie_q;
      ADDR_MTVEC:    old_val = mtvec_q;
      ADDR_MSCRATCH: old_val = mscratch_q;
      ADDR_MEPC:     old_val = mepc_q;
      ADDR_MCAUSE:   old_val = mcause_q;
      ADDR_MIP:      old_val = mip_val;
      ADDR_MCYCLE:   old_val = mcycle_q[31:0];
      ADDR_MCYCLEH:  old_val = mcycle_q[63:32];
      default:       addr_ok = 1'b0;
    endcase
  end

  csr_wdata u_wdata (
    .op       (bus.csr_op_i),
    .rs1_data (bus.rs1_data_i),
    .zimm     (bus.zimm_i),
    .old      (old_val),
    .wdata    (wdata),
    .src_zero (src_zero)
  );

  assign op_ok           = !(bus.csr_op_i inside {CSR_ILL_6, CSR_ILL_7});
  assign illegal         = bus.csr_en_i & (~addr_ok | ~op_ok);
  assign bus.illegal_o   = illegal;
  assign bus.csr_rdata_o = (!rst_n || illegal) ? '0 : old_val;

  // Interrupt arbitration; enables written this cycle only act next cycle
  // because irq is built from registered state.
  assign pend      = mie_q & mip_val;
  assign irq       = mstatus_mie & instr_valid_i & (|pend);
  assign cause     = pend[MEIE_BIT] ? CAUSE_MEI : CAUSE_MTI;
  assign take_mret = mret_i & ~irq;
  // Set/clear with a zero source must not disturb anything (e.g. the counter).
  assign set_clear = !(bus.csr_op_i inside {CSR_RW, CSR_RWI});
  assign csr_we    = bus.csr_en_i & ~illegal & ~irq & ~mret_i & ~(set_clear & src_zero);
  assign vec_base  = mtvec_q & ~32'd3;

  // Fetch redirect for trap entry or mret.
  always_comb begin
    redirect_o    = 1'b0;
    redirect_pc_o = vec_base;
    if (rst_n) begin
      if (irq) begin
        redirect_o = 1'b1;
        if (mtvec_q[0]) redirect_pc_o = vec_base + {{(DW-6){1'b0}}, cause, 2'b00};
      end else if (take_mret) begin
        redirect_o    = 1'b1;
        redirect_pc_o = mepc_q;
      end
    end
  end

  // State update: trap entry beats mret beats CSR write; counter always runs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      // NOTE: every architectural register is cleared; there is no memory array to leave unreset.
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= '0;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mcycle_q     <= '0;
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
      if (irq) begin
        mepc_q       <= pc_i & ~32'd3;
        mcause_q     <= {1'b1, {(DW-5){1'b0}}, cause};
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (take_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_we) begin
        case (bus.csr_addr_i)
          ADDR_MSTATUS: begin
            mstatus_mie  <= wdata[MIE_BIT];
            mstatus_mpie <= wdata[MPIE_BIT];
          end
          ADDR_MIE:      mie_q      <= wdata & MIE_MASK;
          ADDR_MTVEC:    mtvec_q    <= wdata & ~32'd2;
          ADDR_MSCRATCH: mscratch_q <= wdata;
          ADDR_MEPC:     mepc_q     <= wdata & ~32'd3;
          ADDR_MCAUSE:   mcause_q   <= wdata;
          ADDR_MCYCLE:   mcycle_q   <= {mcycle_q[63:32], wdata};
          ADDR_MCYCLEH:  mcycle_q   <= {wdata, mcycle_q[31:0] + 32'd1};
          default:       ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios plus a randomized
// run compared against a behavioural model of the CSR file.
module tb_csr_regfile;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        instr_valid, mret, timer_irq, ext_irq;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  csr_regfile_if bus ();

  csr_regfile dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .pc_i          (pc),
    .instr_valid_i (instr_valid),
    .mret_i        (mret),
    .timer_irq_i   (timer_irq),
    .ext_irq_i     (ext_irq),
    .redirect_o    (redirect),
    .redirect_pc_o (redirect_pc)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic        m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc;

  // Sampled outputs
  logic [31:0] s_rd, s_rpc;
  logic        s_ill, s_rdr;

  localparam int NADDR = 10;
  logic [11:0] addr_tab [NADDR] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'h344, 12'hB00, 12'hB80, 12'h7C0};

  function automatic logic m_addr_ok(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                     12'h342, 12'h344, 12'hB00, 12'hB80};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_mie) * 8) + (32'(m_mpie) * 128);
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (32'(timer_irq) * 128) + (32'(ext_irq) * 2048);
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_ext_pend();
    return m_mie_reg[11] && ext_irq;
  endfunction

  function automatic logic m_irq();
    return m_mie && instr_valid && ((m_mie_reg[7] && timer_irq) || m_ext_pend());
  endfunction

  function automatic logic [31:0] m_code();
    return m_ext_pend() ? 32'd11 : 32'd7;
  endfunction

  function automatic logic exp_ill();
    return bus.csr_en_i && (!m_addr_ok(bus.csr_addr_i) || (3'(bus.csr_op_i) > 3'd5));
  endfunction

  function automatic logic [31:0] exp_rd();
    if (!rst_n || exp_ill()) return 32'd0;
    return m_read(bus.csr_addr_i);
  endfunction

  function automatic logic exp_rdr();
    return rst_n && (m_irq() || mret);
  endfunction

  function automatic logic [31:0] exp_rpc();
    if (m_irq()) return (m_mtvec & ~32'd3) + (m_mtvec[0] ? 4 * m_code() : 32'd0);
    return m_mepc;
  endfunction

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic m_commit();
    logic [31:0] src, old, nv;
    int          kind;
    if (!rst_n) begin
      m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mtvec = 0;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0;
      return;
    end
    if (m_irq()) begin
      m_mepc   = pc & ~32'd3;
      m_mcause = 32'h8000_0000 + m_code();
      m_mpie   = m_mie;
      m_mie    = 0;
      m_cyc    = m_cyc + 1;
    end else if (mret) begin
      m_mie  = m_mpie;
      m_mpie = 1;
      m_cyc  = m_cyc + 1;
    end else if (bus.csr_en_i && !exp_ill()) begin
      src  = (3'(bus.csr_op_i) >= 3'd3) ? 32'(bus.zimm_i) : bus.rs1_data_i;
      kind = int'(3'(bus.csr_op_i)) % 3;
      old  = m_read(bus.csr_addr_i);
      nv   = (kind == 0) ? src : (kind == 1) ? (old | src) : (old & ~src);
      if (kind != 0 && src == 0) begin
        m_cyc = m_cyc + 1;
      end else begin
        case (bus.csr_addr_i)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_mie_reg  = nv & 32'h880;
          12'h305: m_mtvec    = nv & ~32'd2;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & ~32'd3;
          12'h342: m_mcause   = nv;
          default: ;
        endcase
        if (bus.csr_addr_i == 12'hB00)      m_cyc = {m_cyc[63:32], nv};
        else if (bus.csr_addr_i == 12'hB80) m_cyc = {nv, m_cyc[31:0] + 32'd1};
        else                                m_cyc = m_cyc + 1;
      end
    end else begin
      m_cyc = m_cyc + 1;
    end
  endtask

  task automatic set_csr(input logic en, input logic [2:0] op, input logic [11:0] a,
                         input logic [31:0] r, input logic [4:0] z);
    bus.csr_en_i   = en;
    bus.csr_op_i   = csr_op_t'(op);
    bus.csr_addr_i = a;
    bus.rs1_data_i = r;
    bus.zimm_i     = z;
  endtask

  task automatic set_ctl(input logic v, input logic mr, input logic ti, input logic ei,
                         input logic [31:0] p);
    instr_valid = v; mret = mr; timer_irq = ti; ext_irq = ei; pc = p;
  endtask

  // Sample outputs mid-cycle, then take the edge in both DUT and model.
  task automatic run_cycle();
    @(negedge clk);
    s_rd = bus.csr_rdata_o; s_ill = bus.illegal_o;
    s_rdr = redirect; s_rpc = redirect_pc;
    @(posedge clk);
    m_commit();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_ctl(1, 1, 1, 1, 32'h40);
    for (int i = 0; i < NADDR - 1; i++) begin
      set_csr(0, 3'd0, addr_tab[i], 0, 0);
      run_cycle();
      checks++;
      if (s_rd !== 32'd0) begin
        errors++; $display("FAIL reset_rdata addr=%h got=%h want=0", addr_tab[i], s_rd);
      end
      checks++;
      if (s_rdr !== 1'b0) begin
        errors++; $display("FAIL reset_redirect addr=%h got=%b want=0", addr_tab[i], s_rdr);
      end
    end
    rst_n = 1;
    set_ctl(0, 0, 0, 0, 0);
    for (int i = 0; i < NADDR - 1; i++) begin
      int j = (i + 7) % (NADDR - 1);   // counter halves first, before they move
      set_csr(1, 3'd1, addr_tab[j], 0, 0);
      run_cycle();
      checks++;
      if (s_rd !== 32'd0 || s_ill !== 1'b0) begin
        errors++; $display("FAIL post_reset_read addr=%h got=%h/%b want=0/0", addr_tab[j], s_rd, s_ill);
      end
    end
    set_csr(1, 3'd1, 12'h7C0, 0, 0);
    run_cycle();
    checks++;
    if (s_rd !== 32'd0 || s_ill !== 1'b1) begin
      errors++; $display("FAIL unknown_addr got=%h/%b want=0/1", s_rd, s_ill);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] want [4] = '{32'h0, 32'hDEADBEEF, 32'hDEADBEFF, 32'hDEADBEF0};
    set_csr(1, 3'd0, 12'h340, 32'hDEADBEEF, 0); run_cycle();
    checks++; if (s_rd !== want[0]) begin errors++; $display("FAIL scratch_rw got=%h want=%h", s_rd, want[0]); end
    set_csr(1, 3'd1, 12'h340, 32'h10, 0); run_cycle();
    checks++; if (s_rd !== want[1]) begin errors++; $display("FAIL scratch_rs got=%h want=%h", s_rd, want[1]); end
    set_csr(1, 3'd5, 12'h340, 32'hFFFF_FFFF, 5'h0F); run_cycle();
    checks++; if (s_rd !== want[2]) begin errors++; $display("FAIL scratch_rci got=%h want=%h", s_rd, want[2]); end
    set_csr(1, 3'd6, 12'h340, 32'h0, 0); run_cycle();
    checks++; if (s_rd !== 32'd0 || s_ill !== 1'b1) begin errors++; $display("FAIL illegal_op got=%h/%b want=0/1", s_rd, s_ill); end
    set_csr(1, 3'd1, 12'h340, 32'h0, 0); run_cycle();
    checks++; if (s_rd !== want[3]) begin errors++; $display("FAIL scratch_final got=%h want=%h", s_rd, want[3]); end
  endtask

  task automatic test_trap_mret();
    set_csr(1, 3'd0, 12'h304, 32'h880, 0);  run_cycle();
    set_csr(1, 3'd0, 12'h305, 32'h1001, 0); run_cycle();
    set_csr(1, 3'd4, 12'h300, 0, 5'h08);    run_cycle();
    set_csr(0, 3'd0, 12'h340, 0, 0);
    set_ctl(1, 0, 1, 1, 32'h200);
    run_cycle();
    checks++;
    if (s_rdr !== 1'b1 || s_rpc !== 32'h102C) begin
      errors++; $display("FAIL trap_redirect got=%b/%h want=1/0000102c", s_rdr, s_rpc);
    end
    set_ctl(0, 0, 0, 0, 0);
    set_csr(1, 3'd1, 12'h342, 0, 0); run_cycle();
    checks++; if (s_rd !== 32'h8000000B) begin errors++; $display("FAIL trap_mcause got=%h want=8000000b", s_rd); end
    set_csr(1, 3'd1, 12'h341, 0, 0); run_cycle();
    checks++; if (s_rd !== 32'h200) begin errors++; $display("FAIL trap_mepc got=%h want=00000200", s_rd); end
    set_csr(1, 3'd1, 12'h300, 0, 0); run_cycle();
    checks++; if (s_rd !== 32'h80) begin errors++; $display("FAIL trap_mstatus got=%h want=00000080", s_rd); end
    set_csr(0, 3'd0, 12'h300, 0, 0);
    set_ctl(1, 1, 0, 0, 32'h1000); run_cycle();
    checks++;
    if (s_rdr !== 1'b1 || s_rpc !== 32'h200) begin
      errors++; $display("FAIL mret_redirect got=%b/%h want=1/00000200", s_rdr, s_rpc);
    end
    set_ctl(0, 0, 0, 0, 0);
    set_csr(1, 3'd1, 12'h300, 0, 0); run_cycle();
    checks++; if (s_rd !== 32'h88) begin errors++; $display("FAIL mret_mstatus got=%h want=00000088", s_rd); end
  endtask

  task automatic test_irq_vs_write();
    set_csr(1, 3'd0, 12'h340, 32'h12345678, 0);
    set_ctl(1, 0, 1, 0, 32'h300);
    run_cycle();
    checks++;
    if (s_rdr !== 1'b1 || s_rpc !== 32'h101C) begin
      errors++; $display("FAIL irq_write_redirect got=%b/%h want=1/0000101c", s_rdr, s_rpc);
    end
    set_ctl(0, 0, 0, 0, 0);
    set_csr(1, 3'd1, 12'h340, 0, 0); run_cycle();
    checks++; if (s_rd !== 32'hDEADBEF0) begin errors++; $display("FAIL irq_write_suppressed got=%h want=deadbef0", s_rd); end
    set_csr(1, 3'd1, 12'h342, 0, 0); run_cycle();
    checks++; if (s_rd !== 32'h80000007) begin errors++; $display("FAIL irq_timer_cause got=%h want=80000007", s_rd); end
  endtask

  task automatic test_mcycle();
    set_ctl(0, 0, 0, 0, 0);
    set_csr(1, 3'd0, 12'hB80, 32'h0, 0);         run_cycle();
    set_csr(1, 3'd0, 12'hB00, 32'hFFFF_FFFF, 0); run_cycle();
    set_csr(1, 3'd1, 12'hB00, 0, 0); run_cycle();
    checks++; if (s_rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_written got=%h want=ffffffff", s_rd); end
    set_csr(1, 3'd1, 12'hB80, 0, 0); run_cycle();
    checks++; if (s_rd !== 32'h1) begin errors++; $display("FAIL mcycleh_carry got=%h want=00000001", s_rd); end
    set_csr(1, 3'd1, 12'hB00, 0, 0); run_cycle();
    checks++; if (s_rd !== 32'h1) begin errors++; $display("FAIL mcycle_wrapped got=%h want=00000001", s_rd); end
    rst_n = 0; run_cycle(); rst_n = 1;
    set_csr(1, 3'd1, 12'hB00, 0, 0); run_cycle();
    checks++; if (s_rd !== 32'h0) begin errors++; $display("FAIL mcycle_reset got=%h want=0", s_rd); end
    set_csr(1, 3'd1, 12'hB80, 0, 0); run_cycle();
    checks++; if (s_rd !== 32'h0) begin errors++; $display("FAIL mcycleh_reset got=%h want=0", s_rd); end
  endtask

  task automatic test_random();
    logic [31:0] e_rd, e_rpc;
    logic        e_ill, e_rdr;
    for (int n = 0; n < 400; n++) begin
      set_csr(($urandom % 4) != 0,
              ($urandom % 10 == 0) ? 3'(6 + $urandom % 2) : 3'($urandom % 6),
              addr_tab[$urandom % NADDR],
              ($urandom % 4 == 0) ? 32'd0 : $urandom,
              5'($urandom));
      set_ctl(1'($urandom), ($urandom % 10) == 0, ($urandom % 4) == 0,
              ($urandom % 4) == 0, $urandom);
      e_rd = exp_rd(); e_ill = exp_ill(); e_rdr = exp_rdr(); e_rpc = exp_rpc();
      run_cycle();
      checks++;
      if (s_rd !== e_rd) begin errors++; $display("FAIL rand_rdata n=%0d got=%h want=%h", n, s_rd, e_rd); end
      checks++;
      if (s_ill !== e_ill) begin errors++; $display("FAIL rand_illegal n=%0d got=%b want=%b", n, s_ill, e_ill); end
      checks++;
      if (s_rdr !== e_rdr) begin errors++; $display("FAIL rand_redirect n=%0d got=%b want=%b", n, s_rdr, e_rdr); end
      if (e_rdr) begin
        checks++;
        if (s_rpc !== e_rpc) begin errors++; $display("FAIL rand_redirect_pc n=%0d got=%h want=%h", n, s_rpc, e_rpc); end
      end
    end
  endtask

  initial begin
    rst_n = 0;
    set_csr(0, 3'd0, 12'h300, 0, 0);
    set_ctl(0, 0, 0, 0, 0);
    m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mtvec = 0;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0;
    #1;
    test_reset();
    test_scratch();
    test_trap_mret();
    test_irq_vs_write();
    test_mcycle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
